// File: rtl/demux8_rr_sched_pkg.sv
// Shared widths, FSM state type and one-hot helper for the 8-way demux scheduler.
package demux8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux8_rr_sched_if.sv
// Request/grant/select bundle between the requesting units and the scheduler.
interface demux8_rr_sched_if;
  import demux8_pkg::*;

  logic             arb_en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_vld;
  logic             beat;
  logic             busy;

  modport master (
    output arb_en, req,
    input  gnt, sel, sel_vld, beat, busy
  );

  modport slave (
    input  arb_en, req,
    output gnt, sel, sel_vld, beat, busy
  );

endinterface

// File: rtl/demux8_rr_sched_rr_pick8.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping 7->0.
module rr_pick8
  import demux8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Rotating the doubled vector puts ptr at bit 0, so a plain low-first search gives RR order.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    found = |rot;
    off   = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (rot[SEL_W'(k - 1)]) off = SEL_W'(k - 1);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/demux8_rr_sched.sv
// Round-robin scheduler driving the 8-way demux select/enable with bounded bursts.
module demux8_rr_sched
  import demux8_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  demux8_rr_sched_if.slave  bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             found;
  logic [SEL_W-1:0] win;
  logic             beat;
  logic             grant_ok;
  logic             release_now;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  assign beat     = |(gnt_q & bus.req);
  assign grant_ok = bus.arb_en & found;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = BUSY;
          gnt_d   = onehot8(win);
          sel_d   = win;
          ptr_d   = win + 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        release_now = !beat || (cnt_q == CNT_W'(MAX_BURST - 1));
        if (!release_now) begin
          cnt_d = cnt_q + 1'b1;
        end else if (grant_ok) begin
          // Zero-bubble hand-off; ptr already sits past the owner, so it ranks last.
          gnt_d = onehot8(win);
          sel_d = win;
          ptr_d = win + 1'b1;
          cnt_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.sel_vld = (state_q == BUSY);
  assign bus.busy    = (state_q == BUSY);
  assign bus.beat    = beat;

endmodule

// File: tb/tb_demux8_rr_sched.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations, monitor checks on negedge.
module tb_demux8_rr_sched;

  logic clk;
  logic rst_n;

  demux8_rr_sched_if bus();

  demux8_rr_sched #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
    logic       beat;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_vec;
  int   n_err;
  logic [13:0] got, want;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string name, input logic rst, input logic en,
                      input logic [7:0] r, input logic [7:0] eg, input logic [2:0] es,
                      input logic ev, input logic eb);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n      = rst;
    bus.arb_en = en;
    bus.req    = r;
    x.name = name; x.gnt = eg; x.sel = es; x.vld = ev; x.beat = eb;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      got  = {bus.gnt, bus.sel, bus.sel_vld, bus.beat, bus.busy};
      want = {e.gnt, e.sel, e.vld, e.beat, e.vld};
      if (got !== want) begin
        n_err++;
        $display("FAIL %s @%0t: got gnt=%h sel=%0d vld=%b beat=%b busy=%b, expected gnt=%h sel=%0d vld=%b beat=%b busy=%b",
                 e.name, $time, bus.gnt, bus.sel, bus.sel_vld, bus.beat, bus.busy,
                 e.gnt, e.sel, e.vld, e.beat, e.vld);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.arb_en = 1'b0;
    bus.req    = 8'h00;

    // reset with all requesters asserting
    step("rst_hold",  0, 1, 8'hFF, 8'h00, 0, 0, 0);
    step("rst_hold2", 0, 1, 8'hFF, 8'h00, 0, 0, 0);
    step("rst_rel",   1, 1, 8'hFF, 8'h00, 0, 0, 0);
    repeat (4) step("ff_own0", 1, 1, 8'hFF, 8'h01, 0, 1, 1);
    step("ff_own1",   1, 1, 8'hFF, 8'h02, 1, 1, 1);

    // sole requester is regranted with no idle cycle
    step("sole_rst",  0, 1, 8'h01, 8'h00, 0, 0, 0);
    step("sole_idle", 1, 1, 8'h01, 8'h00, 0, 0, 0);
    repeat (4) step("sole_b1", 1, 1, 8'h01, 8'h01, 0, 1, 1);
    repeat (2) step("sole_b2", 1, 1, 8'h01, 8'h01, 0, 1, 1);

    // wrap-around between requesters 0 and 7
    step("wrap_rst",  0, 1, 8'h81, 8'h00, 0, 0, 0);
    step("wrap_idle", 1, 1, 8'h81, 8'h00, 0, 0, 0);
    repeat (4) step("wrap_0", 1, 1, 8'h81, 8'h01, 0, 1, 1);
    repeat (4) step("wrap_7", 1, 1, 8'h81, 8'h80, 7, 1, 1);
    step("wrap_back", 1, 1, 8'h81, 8'h01, 0, 1, 1);

    // owner drops request early, hand-off to requester 5
    step("drop_rst",  0, 1, 8'h08, 8'h00, 0, 0, 0);
    step("drop_idle", 1, 1, 8'h08, 8'h00, 0, 0, 0);
    repeat (2) step("drop_beat", 1, 1, 8'h28, 8'h08, 3, 1, 1);
    step("drop_nobeat", 1, 1, 8'h20, 8'h08, 3, 1, 0);
    step("drop_to5",  1, 1, 8'h20, 8'h20, 5, 1, 1);

    // arb_en dropped mid-burst, then reset mid-burst
    step("en_rst",    0, 1, 8'h04, 8'h00, 0, 0, 0);
    step("en_idle",   1, 1, 8'h04, 8'h00, 0, 0, 0);
    step("en_b0",     1, 1, 8'hFF, 8'h04, 2, 1, 1);
    repeat (3) step("en_off_b", 1, 0, 8'hFF, 8'h04, 2, 1, 1);
    repeat (2) step("en_off_idle", 1, 0, 8'hFF, 8'h00, 2, 0, 0);
    step("en_on_idle", 1, 1, 8'hFF, 8'h00, 2, 0, 0);
    repeat (2) step("en_own3", 1, 1, 8'hFF, 8'h08, 3, 1, 1);
    step("mid_rst",   0, 1, 8'hFF, 8'h00, 0, 0, 0);
    step("mid_rel",   1, 1, 8'hFF, 8'h00, 0, 0, 0);
    step("mid_own0",  1, 1, 8'hFF, 8'h01, 0, 1, 1);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux8_rr_sched.md
Name: demux8_rr_sched

Overview:
Round-robin scheduler that shares the 8-way demultiplexer among 8 requesters. It issues one-hot grants and drives the demux 3-bit select and enable. A grant is held for a bounded burst of beats, then handed off fairly. It sits between the requesting units and the demux select/enable inputs, so only one destination is ever driven per cycle.

Parameters:
MAX_BURST, 4, maximum beats per grant before forced hand-off (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
arb_en  input  1  1 = new grants allowed; 0 = finish current burst, then stop granting
req  input  8  request per requester; bit i = requester i
gnt  output  8  registered one-hot grant, all zero when idle
sel  output  3  registered binary index of the granted requester, goes to demux select
sel_vld  output  1  registered, 1 while any grant is held
beat  output  1  combinational |(gnt & req); demux data enable; one transfer per cycle when high
busy  output  1  registered, equals sel_vld; used as status/debug

Behaviour:
- Reset (async, rst_n=0): gnt=0, sel=0, sel_vld=0, busy=0, beat=0. Internal state: state=IDLE, ptr=0, cnt=0. Reset mid-burst aborts the burst immediately; no beat completes.
- Round-robin pick: search req starting at index ptr, ascending, wrapping 7->0. The first set bit wins. On any grant, ptr <= winner+1 mod 8.
- States:
  - IDLE: at an edge, if arb_en and |req, go to BUSY with gnt=onehot(winner), sel=winner, sel_vld=1, cnt=0. Otherwise stay in IDLE. Latency from req to gnt is 1 cycle.
  - BUSY, owner o: a beat is a cycle with req[o]=1. At each edge:
    - beat and cnt+1 < MAX_BURST: cnt <= cnt+1, hold the grant.
    - beat and cnt+1 == MAX_BURST: release (burst limit).
    - no beat (req[o]=0): release; that cycle transfers nothing.
  - On release: if arb_en and any req is pending, re-pick from ptr and switch gnt/sel to the new winner at the same edge (zero-bubble hand-off), cnt=0. Otherwise go to IDLE with gnt=0 and sel_vld=0; sel holds its last value.
- Fairness: ptr has already advanced past o, so o is lowest priority at hand-off. o is regranted back-to-back only if it is the sole requester.
- arb_en=0 during BUSY: the current burst runs to normal completion; no new grant follows; goes to IDLE.
- cnt width is 4 bits; it never exceeds MAX_BURST-1.
- gnt is always one-hot or zero. sel == index(gnt) whenever sel_vld=1.
- req changes mid-burst on non-owner bits have no effect until release.

Decomposition:
- Package demux8_pkg:
  - N_REQ=8, SEL_W=3, CNT_W=4.
  - State enum {IDLE, BUSY}.
  - Function onehot8(idx).
- Sub-module rr_pick8: combinational. Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]. Implement as a doubled-vector priority search; unit-testable alone.

Test Plan:
- Reset with req=8'hFF held -> gnt=0 while rst_n=0. The first edge after release gives gnt=8'h01, sel=0.
- req=8'h01 held, MAX_BURST=4 -> 4 beats on requester 0; at the 4th-beat edge it is regranted (sole requester) with cnt=0 and no idle cycle.
- req=8'h81 held from IDLE, ptr=0 -> gnt sequence 01 (4 cycles), 80 (4 cycles), 01; sel 0, 7, 0 (wrap-around).
- Requester 3 granted, drops req after 2 beats while req[5]=1 -> one cycle with beat=0, then gnt=8'h20, sel=5 at that edge.
- arb_en deasserted mid-burst with req=8'hFF -> current burst completes its 4 beats, then gnt=0 and sel_vld=0 until arb_en=1.
- rst_n pulsed low mid-burst (cnt=2) -> gnt=0 immediately (async). After release, grant restarts at requester 0 (ptr=0).
